// File: rtl/subtract_pkg.sv
// Shared constants for the background-subtraction datapath.
package subtract_pkg;

  localparam int unsigned CH_DEF  = 3;   // channels per pixel
  localparam int unsigned CW_DEF  = 8;   // bits per channel
  localparam int unsigned STATS_W = 32;  // width of the optional push/motion counters

endpackage

// File: rtl/abs_diff_sum.sv
// Combinational helpers for bg_subtract_pipe.
// The first half forms the per-channel absolute differences |fr - bg| feeding s1.
// The second half is the adder tree that sums the s1 differences for s2.
module abs_diff_sum
  import subtract_pkg::*;
#(
  parameter int unsigned CH = CH_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned SW = CW + $clog2(CH)
) (
  input  logic [CH*CW-1:0] fr_i,
  input  logic [CH*CW-1:0] bg_i,
  output logic [CH*CW-1:0] diff_o,
  input  logic [CH*CW-1:0] diff_i,
  output logic [SW-1:0]    sum_o
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CW-1:0] fr_c;
    logic [CW-1:0] bg_c;
    assign fr_c = fr_i[c*CW +: CW];
    assign bg_c = bg_i[c*CW +: CW];
    // Subtract the smaller from the larger so the result never wraps.
    assign diff_o[c*CW +: CW] = (fr_c >= bg_c) ? (fr_c - bg_c) : (bg_c - fr_c);
  end

  // Zero-extend each channel difference to SW bits and accumulate.
  always_comb begin
    sum_o = '0;
    for (int c = 0; c < CH; c++) begin
      sum_o = sum_o + SW'(diff_i[c*CW +: CW]);
    end
  end

endmodule

// File: rtl/bg_subtract_pipe.sv
// Two-stage background-subtraction pipeline.
// It pops one background and one frame pixel together and forms the per-channel absolute
// differences in s1. In s2 it sums them and compares the sum against a live threshold.
// It then pushes an all-ones (motion) or all-zeros mask word.
// Optional feature: define SUBTRACT_STATS_EN to add the stats_clear input and the
// pix_count/motion_count counters.
module bg_subtract_pipe
  import subtract_pkg::*;
#(
  parameter int unsigned CH = CH_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned SW = CW + $clog2(CH),
  localparam int unsigned PW = CH * CW
) (
  input  logic               clock,
  input  logic               reset,
`ifdef SUBTRACT_STATS_EN
  input  logic               stats_clear,
  output logic [STATS_W-1:0] pix_count,
  output logic [STATS_W-1:0] motion_count,
`endif
  input  logic [SW-1:0]      threshold,
  output logic               bg_rd_en,
  input  logic               bg_empty,
  input  logic [PW-1:0]      bg_dout,
  output logic               fr_rd_en,
  input  logic               fr_empty,
  input  logic [PW-1:0]      fr_dout,
  output logic               out_wr_en,
  input  logic               out_full,
  output logic [PW-1:0]      out_din
);

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_diff_q, s1_diff_d;
  logic          s2_valid_q, s2_valid_d;
  logic [SW-1:0] s2_sum_q, s2_sum_d;

  logic          adv1, adv2, pop, push, motion;
  logic [PW-1:0] in_diff;
  logic [SW-1:0] s1_sum;

  abs_diff_sum #(
    .CH (CH),
    .CW (CW),
    .SW (SW)
  ) u_abs_diff_sum (
    .fr_i   (fr_dout),
    .bg_i   (bg_dout),
    .diff_o (in_diff),
    .diff_i (s1_diff_q),
    .sum_o  (s1_sum)
  );

  // Advance chain: a stage moves when it is empty or its successor moves this cycle.
  assign adv2 = !s2_valid_q || !out_full;
  assign adv1 = !s1_valid_q || adv2;

  assign pop      = !reset && !bg_empty && !fr_empty && adv1;
  assign bg_rd_en = pop;
  assign fr_rd_en = pop;

  // Threshold is compared live so a change applies to whatever pixel sits in s2 now.
  assign motion    = s2_sum_q > threshold;
  assign push      = !reset && s2_valid_q && !out_full;
  assign out_wr_en = push;
  assign out_din   = (!reset && s2_valid_q && motion) ? {PW{1'b1}} : {PW{1'b0}};

  // Next-state for both stages; each stage holds when it cannot advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    if (adv1) begin
      s1_valid_d = pop;
      s1_diff_d  = in_diff;
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = s1_sum;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

`ifdef SUBTRACT_STATS_EN
  logic [STATS_W-1:0] pix_count_q, pix_count_d;
  logic [STATS_W-1:0] motion_count_q, motion_count_d;

  // Counter next-state; clear wins over a same-cycle increment, counts wrap naturally.
  always_comb begin
    pix_count_d    = pix_count_q;
    motion_count_d = motion_count_q;
    if (stats_clear) begin
      pix_count_d    = '0;
      motion_count_d = '0;
    end else if (push) begin
      pix_count_d = pix_count_q + 1'b1;
      if (motion) begin
        motion_count_d = motion_count_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_count_q    <= '0;
      motion_count_q <= '0;
    end else begin
      pix_count_q    <= pix_count_d;
      motion_count_q <= motion_count_d;
    end
  end

  assign pix_count    = pix_count_q;
  assign motion_count = motion_count_q;
`endif

endmodule

// File: tb/tb_bg_subtract_pipe.sv
// Self-checking bench for bg_subtract_pipe with queue-modelled FIFOs and a reference model.
// Stats tests are compiled in when SUBTRACT_STATS_EN is defined.
module tb_bg_subtract_pipe;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int SW = 10;
  localparam int PW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [SW-1:0] threshold = '0;
  logic          bg_rd_en, fr_rd_en, out_wr_en;
  logic          bg_empty = 1'b1, fr_empty = 1'b1;
  logic [PW-1:0] bg_dout = '0, fr_dout = '0;
  logic          out_full = 1'b0;
  logic [PW-1:0] out_din;
`ifdef SUBTRACT_STATS_EN
  logic          stats_clear = 1'b0;
  logic [31:0]   pix_count, motion_count;
`endif

  always #5 clock = ~clock;

  bg_subtract_pipe #(
    .CH (CH),
    .CW (CW),
    .SW (SW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef SUBTRACT_STATS_EN
    .stats_clear  (stats_clear),
    .pix_count    (pix_count),
    .motion_count (motion_count),
`endif
    .threshold    (threshold),
    .bg_rd_en     (bg_rd_en),
    .bg_empty     (bg_empty),
    .bg_dout      (bg_dout),
    .fr_rd_en     (fr_rd_en),
    .fr_empty     (fr_empty),
    .fr_dout      (fr_dout),
    .out_wr_en    (out_wr_en),
    .out_full     (out_full),
    .out_din      (out_din)
  );

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] bg_q[$];
  logic [PW-1:0] fr_q[$];
  int unsigned   exp_sum_q[$];
  int            exp_cyc_q[$];
  int            push_cyc_q[$];
  int            cyc = 0;
  int            pop_cnt = 0;
  int            push_cnt = 0;
  logic [PW-1:0] last_din = '0;
  bit            lat_chk = 1'b0;

  // Reference: sum of per-channel absolute differences, plain integer arithmetic.
  function automatic int unsigned ref_sum(input logic [PW-1:0] f, input logic [PW-1:0] b);
    int unsigned s = 0;
    for (int c = 0; c < CH; c++) begin
      int a, d;
      a = int'(f[c*CW +: CW]);
      d = int'(b[c*CW +: CW]);
      s += (a > d) ? (a - d) : (d - a);
    end
    return s;
  endfunction

  task automatic update_fifo_ports();
    bg_empty = (bg_q.size() == 0);
    fr_empty = (fr_q.size() == 0);
    bg_dout  = bg_empty ? '0 : bg_q[0];
    fr_dout  = fr_empty ? '0 : fr_q[0];
  endtask

  task automatic add_pair(input logic [PW-1:0] f, input logic [PW-1:0] b);
    fr_q.push_back(f);
    bg_q.push_back(b);
    update_fifo_ports();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Monitor: samples at the falling edge, scores pushes, records pops, pops model FIFOs.
  initial begin
    logic s_pop, s_frpop, s_push, s_rst;
    logic [PW-1:0] s_din, exp_mask;
    logic [SW-1:0] s_thr;
    int unsigned sum;
    int pc;
    update_fifo_ports();
    forever begin
      @(negedge clock);
      s_pop = bg_rd_en; s_frpop = fr_rd_en; s_push = out_wr_en;
      s_din = out_din; s_thr = threshold; s_rst = reset;
      checks++;
      if (s_pop !== s_frpop) begin
        failures++;
        $display("FAIL rd_en_pair cyc=%0d bg_rd_en=%b fr_rd_en=%b required equal", cyc, s_pop,
                 s_frpop);
      end
      if (s_rst === 1'b1) begin
        checks++;
        if (s_pop !== 1'b0 || s_push !== 1'b0) begin
          failures++;
          $display("FAIL reset_quiet cyc=%0d pop=%b push=%b required 0/0", cyc, s_pop, s_push);
        end
        exp_sum_q.delete();
        exp_cyc_q.delete();
      end
      if (s_push === 1'b1) begin
        push_cnt++;
        last_din = s_din;
        push_cyc_q.push_back(cyc);
        checks++;
        if (exp_sum_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_push cyc=%0d out_din=%h required no push", cyc, s_din);
        end else begin
          sum = exp_sum_q.pop_front();
          pc = exp_cyc_q.pop_front();
          exp_mask = (sum > int'(s_thr)) ? {PW{1'b1}} : {PW{1'b0}};
          if (s_din !== exp_mask) begin
            failures++;
            $display("FAIL mask cyc=%0d out_din=%h required %h (sum=%0d thr=%0d)", cyc, s_din,
                     exp_mask, sum, s_thr);
          end
          if (lat_chk) begin
            checks++;
            if (cyc - pc != 2) begin
              failures++;
              $display("FAIL latency cyc=%0d got %0d cycles required 2", cyc, cyc - pc);
            end
          end
        end
      end
      if (s_pop === 1'b1) begin
        pop_cnt++;
        if (bg_q.size() == 0 || fr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty cyc=%0d popped with empty FIFO, required no pop", cyc);
        end else begin
          exp_sum_q.push_back(ref_sum(fr_q[0], bg_q[0]));
          exp_cyc_q.push_back(cyc);
        end
      end
      @(posedge clock);
      cyc++;
      #1;
      if (s_pop === 1'b1 && bg_q.size() > 0 && fr_q.size() > 0) begin
        void'(bg_q.pop_front());
        void'(fr_q.pop_front());
      end
      update_fifo_ports();
    end
  end

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((bg_q.size() != 0 || fr_q.size() != 0 || exp_sum_q.size() != 0) && n < max_cycles) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d after %0d cycles required 0", exp_sum_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_full = 1'b0;
    add_pair(24'h123456, 24'h654321);
    tick(3);
    checks++;
    if (bg_rd_en !== 1'b0 || fr_rd_en !== 1'b0 || out_wr_en !== 1'b0 || out_din !== '0) begin
      failures++;
      $display("FAIL reset_outputs rd=%b/%b wr=%b din=%h required 0/0/0/000000", bg_rd_en,
               fr_rd_en, out_wr_en, out_din);
    end
    bg_q.delete();
    fr_q.delete();
    update_fifo_ports();
    reset = 1'b0;
    tick(1);
    checks++;
    if (out_wr_en !== 1'b0 || out_din !== '0 || bg_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset wr=%b din=%h rd=%b required 0/000000/0", out_wr_en,
               out_din, bg_rd_en);
    end
  endtask

  task automatic test_equal();
    int p0 = push_cnt;
    lat_chk = 1'b1;
    threshold = '0;
    add_pair(24'h808080, 24'h808080);
    wait_drain(20);
    tick(3);
    checks++;
    if (push_cnt - p0 != 1 || last_din !== 24'h000000) begin
      failures++;
      $display("FAIL equal_pixels pushes=%0d din=%h required 1/000000", push_cnt - p0, last_din);
    end
  endtask

  task automatic run_one(input string name, input logic [PW-1:0] f, input logic [PW-1:0] b,
                         input int thr, input logic [PW-1:0] want);
    int p0 = push_cnt;
    threshold = SW'(thr);
    add_pair(f, b);
    wait_drain(20);
    tick(3);
    checks++;
    if (push_cnt - p0 != 1 || last_din !== want) begin
      failures++;
      $display("FAIL %s pushes=%0d din=%h required 1/%h", name, push_cnt - p0, last_din, want);
    end
  endtask

  task automatic test_threshold_edges();
    run_one("thr_eq_16", 24'h102030, 24'h101030, 16, 24'h000000);
    run_one("thr_15", 24'h102030, 24'h101030, 15, 24'hFFFFFF);
    run_one("fr_lt_bg_764", 24'h000000, 24'hFFFFFF, 764, 24'hFFFFFF);
    run_one("fr_lt_bg_765", 24'h000000, 24'hFFFFFF, 765, 24'h000000);
    lat_chk = 1'b0;
  endtask

  task automatic test_backpressure();
    int p0, q0, rel_cyc;
    bit consec = 1'b1;
    threshold = SW'($urandom_range(0, 765));
    out_full = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 6; i++) add_pair(PW'($urandom), PW'($urandom));
    tick(5);
    checks++;
    if (pop_cnt - p0 != 2 || bg_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold pops=%0d rd_en=%b required 2/0", pop_cnt - p0, bg_rd_en);
    end
    tick(1);
    checks++;
    if (pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL bp_hold_late pops=%0d required 2", pop_cnt - p0);
    end
    q0 = push_cyc_q.size();
    rel_cyc = cyc;
    out_full = 1'b0;
    wait_drain(30);
    tick(3);
    checks++;
    if (push_cyc_q.size() - q0 != 6) begin
      failures++;
      $display("FAIL bp_push_count pushes=%0d required 6", push_cyc_q.size() - q0);
    end else begin
      for (int i = 0; i < 6; i++) if (push_cyc_q[q0+i] != rel_cyc + i) consec = 1'b0;
      if (!consec) begin
        failures++;
        $display("FAIL bp_consecutive first_push=%0d last_push=%0d required %0d..%0d",
                 push_cyc_q[q0], push_cyc_q[q0+5], rel_cyc, rel_cyc + 5);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int p0, q0;
    threshold = '0;
    out_full = 1'b1;
    p0 = pop_cnt;
    add_pair(24'h0000FF, 24'h000000);
    add_pair(24'h00FF00, 24'h000000);
    add_pair(24'h445566, 24'h445566);
    tick(4);
    checks++;
    if (pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL mid_fill pops=%0d required 2", pop_cnt - p0);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    out_full = 1'b0;
    q0 = push_cnt;
    wait_drain(20);
    tick(3);
    checks++;
    if (push_cnt - q0 != 1 || last_din !== 24'h000000) begin
      failures++;
      $display("FAIL mid_reset pushes=%0d din=%h required 1/000000", push_cnt - q0, last_din);
    end
  endtask

  task automatic test_random();
    int p0 = push_cnt;
    int popped0 = pop_cnt;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        bg_q.push_back(PW'($urandom));
      end
      if ($urandom_range(0, 3) != 0) begin
        fr_q.push_back(PW'($urandom));
      end
      update_fifo_ports();
      out_full = ($urandom_range(0, 2) == 0);
      threshold = SW'($urandom_range(0, 765));
      tick(1);
    end
    while (bg_q.size() < fr_q.size()) bg_q.push_back(PW'($urandom));
    while (fr_q.size() < bg_q.size()) fr_q.push_back(PW'($urandom));
    update_fifo_ports();
    out_full = 1'b0;
    wait_drain(1000);
    tick(3);
    checks++;
    if (push_cnt - p0 != pop_cnt - popped0) begin
      failures++;
      $display("FAIL random_conserve pushes=%0d required %0d", push_cnt - p0, pop_cnt - popped0);
    end
  endtask

`ifdef SUBTRACT_STATS_EN
  task automatic test_stats();
    int p0;
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
    threshold = '0;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 1 || i % 5 == 3) add_pair(24'h010203, 24'h030201);
      else add_pair(24'hA5A5A5, 24'hA5A5A5);
    end
    wait_drain(40);
    tick(3);
    checks++;
    if (pix_count !== 32'd10 || motion_count !== 32'd4) begin
      failures++;
      $display("FAIL stats_counts pix=%0d motion=%0d required 10/4", pix_count, motion_count);
    end
    out_full = 1'b1;
    add_pair(24'hFF0000, 24'h000000);
    tick(4);
    p0 = push_cnt;
    out_full = 1'b0;
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
    checks++;
    if (pix_count !== 32'd0 || motion_count !== 32'd0 || push_cnt - p0 != 1) begin
      failures++;
      $display("FAIL stats_clear_prio pix=%0d motion=%0d pushes=%0d required 0/0/1", pix_count,
               motion_count, push_cnt - p0);
    end
    wait_drain(20);
  endtask
`endif

  initial begin
    test_reset();
    test_equal();
    test_threshold_edges();
    test_backpressure();
    test_reset_midstream();
    test_random();
`ifdef SUBTRACT_STATS_EN
    test_stats();
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_subtract_pipe.md
# bg_subtract_pipe

Parametrised, fully pipelined background-subtraction block for the motion-detection datapath. It pops one background pixel and one frame pixel per cycle from two FIFOs. It computes the per-channel absolute-difference sum, compares it against a runtime threshold, and pushes an all-ones or all-zeros motion mask word to the output FIFO. It sustains one pixel per cycle under backpressure. It replaces the two-cycle, exact-equality subtractor.

## Interface
Reset is synchronous and active-high. The block uses a single clock.

Parameters:
- CH, 3: channels per pixel.
- CW, 8: bits per channel. Pixel width PW = CH*CW.
- SW, CW+$clog2(CH): width of the absolute-difference sum and of the threshold.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- threshold  in  SW  motion threshold. Sampled in stage 2 of each pixel.
- bg_rd_en  out  1  pop background FIFO.
- bg_empty  in  1  background FIFO empty.
- bg_dout  in  PW  background pixel. Valid when !bg_empty (first-word fall-through).
- fr_rd_en  out  1  pop frame FIFO.
- fr_empty  in  1  frame FIFO empty.
- fr_dout  in  PW  frame pixel. Valid when !fr_empty.
- out_wr_en  out  1  push output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  PW  motion mask word.
- SUBTRACT_STATS_EN only: stats_clear in 1; pix_count out 32; motion_count out 32.

## Operation
- Two pipeline stages, each holding a valid bit plus data.
  - Stage 1 (s1): CH per-channel unsigned absolute differences |fr_c − bg_c|, each CW bits.
  - Stage 2 (s2): motion = (Σ diffs, zero-extended to SW) > threshold. The comparison is strict and unsigned.
- Mask is {PW{1'b1}} when motion is true, otherwise {PW{1'b0}}. With threshold 0, any difference gives motion.
- Advance terms: adv2 = !s2_valid | !out_full; adv1 = !s1_valid | adv2.
- Pop: bg_rd_en = fr_rd_en = !reset & !bg_empty & !fr_empty & adv1.
  - Both FIFOs are always popped together. One empty FIFO stalls both.
- out_wr_en = s2_valid & !out_full. out_din = s2 mask when s2_valid, otherwise 0.
- A stage holds its contents when it cannot advance. No pixel is dropped or duplicated, and order is preserved.
- Reset values:
  - s1_valid, s2_valid: 0. Stage data: 0.
  - All enables: 0. out_din: 0.
  - Counters: 0.
- Reset mid-stream: in-flight pixels are discarded. No pop or push occurs in any cycle with reset high.

## Timing
- Latency: a pop in cycle N produces out_wr_en in cycle N+2 when out_full is low.
- Throughput: 1 pixel per cycle when both inputs are non-empty and out_full is low.
- Under sustained out_full, at most 2 pixels are held (s1 + s2). Popping stops once both stages are valid.
- out_full deasserting in cycle M gives a push in M. Popping resumes in M the same cycle, through the advance chain with no bubble.
- Input-empty bubbles propagate as invalid stages. Pushes never occur from an invalid stage.
- threshold changes take effect on the pixel in s2 in the cycle of the change.

## Configuration
- SUBTRACT_STATS_EN defined:
  - pix_count increments on each push.
  - motion_count increments on each push whose mask is all-ones.
  - Both counters are 32-bit and wrap from 2^32−1 to 0.
  - stats_clear sets both counters to 0 and has priority over a same-cycle increment.
- SUBTRACT_STATS_EN undefined: the three stats ports and the counters are absent. Datapath behaviour is identical.

## Structure
- Package subtract_pkg holds default constants CH_DEF=3, CW_DEF=8 and the STATS_W=32 constant.
- Sub-module abs_diff_sum, purely combinational, parametrised by CH/CW/SW. It provides the per-channel absolute differences for s1 and the adder tree for s2.
- Pipeline registers and the advance logic stay in bg_subtract_pipe.

## Test plan
- Equal pixels: fr=bg=0x808080, threshold=0 → single push of out_din=0x000000 exactly 2 cycles after the pop.
- Threshold edge (fr=0x102030, bg=0x101030, sum=16): threshold=16 → 0x000000. threshold=15 → 0xFFFFFF.
- fr<bg: fr=0x000000, bg=0xFFFFFF (sum=765). threshold=764 → 0xFFFFFF. threshold=765 → 0x000000.
- Backpressure: queue 6 pixel pairs, hold out_full=1 for 5 cycles from the first push.
  - Exactly 2 pops occur, then rd_en stays 0.
  - After release, the 6 masks arrive in order with one push per cycle.
- Reset mid-stream: assert reset for 1 cycle with s1 and s2 valid.
  - No push or pop occurs in that cycle.
  - The next push corresponds to the first pair popped after reset.
- SUBTRACT_STATS_EN: 10 pushes with 4 motion masks → pix_count=10, motion_count=4. stats_clear asserted coincident with a push → both counters 0 next cycle.
